// File: rtl/pll_clk_monitor_pkg.sv
// Shared types and default constants for the PLL clock monitor.
// Defaults describe a 6 MHz PLL measured against a 27 MHz board clock over 1 ms.
package pll_clk_monitor_pkg;
   typedef enum logic {ACQUIRE = 1'b0, RUN = 1'b1} state_t;

   localparam int DEF_GATE_CYCLES  = 27000;
   localparam int DEF_EXP_EDGES    = 6000;
   localparam int DEF_TOL          = 60;
   localparam int DEF_GOOD_WINDOWS = 4;
   localparam int DEF_CNT_W        = 16;
endpackage

// File: rtl/pll_clk_monitor_sync_edge_det.sv
// Brings an asynchronous clock into the clk domain and flags each rising edge.
// Latency: a rise is visible on edge_pulse after two clk edges, no backpressure.
module sync_edge_det (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic edge_pulse
);
   logic sync1;
   logic sync2;
   logic dly;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
         dly   <= 1'b0;
      end else begin
         sync1 <= din;
         sync2 <= sync1;
         dly   <= sync2;
      end
   end

   assign edge_pulse = sync2 & ~dly;
endmodule

// File: rtl/pll_clk_monitor.sv
// Counts mon_clk rising edges per gate window, checks them against a band and
// sequences the downstream reset; results register one clk after window close.
module pll_clk_monitor
   import pll_clk_monitor_pkg::*;
#(
   parameter int GATE_CYCLES  = DEF_GATE_CYCLES,
   parameter int EXP_EDGES    = DEF_EXP_EDGES,
   parameter int TOL          = DEF_TOL,
   parameter int GOOD_WINDOWS = DEF_GOOD_WINDOWS,
   parameter int CNT_W        = DEF_CNT_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             mon_clk,
   input  logic             clr_fault,
   output logic             rst_out,
   output logic             freq_ok,
   output logic [CNT_W-1:0] edge_count,
   output logic             count_valid,
   output logic             fault_sticky
);
   localparam int GW  = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
   localparam int GCW = $clog2(GOOD_WINDOWS + 1);
   localparam int XW  = CNT_W + 1;

   localparam logic [GW-1:0]    GATE_LAST = GW'(GATE_CYCLES - 1);
   localparam logic [GCW-1:0]   GOOD_LAST = GCW'(GOOD_WINDOWS - 1);
   localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
   localparam logic [XW-1:0]    EXP_X     = XW'(EXP_EDGES);
   localparam logic [XW-1:0]    TOL_X     = XW'(TOL);

   logic             edge_pulse;
   logic [GW-1:0]    gate_cnt;
   logic [CNT_W-1:0] acc;
   logic [CNT_W-1:0] acc_inc;
   logic [XW-1:0]    sum_x;
   logic [XW-1:0]    diff;
   logic             close;
   logic             in_band;
   logic [GCW-1:0]   good_cnt;
   state_t           state;

   sync_edge_det u_sync (
      .clk        (clk),
      .rst        (rst),
      .din        (mon_clk),
      .edge_pulse (edge_pulse)
   );

   assign close = (gate_cnt == GATE_LAST);

   always_comb begin
      acc_inc = acc;
      if (edge_pulse && (acc != CNT_MAX))
         acc_inc = acc + 1'b1;
   end

   // Band check on one extra bit so the subtraction never wraps.
   assign sum_x   = {1'b0, acc_inc};
   assign diff    = (sum_x >= EXP_X) ? (sum_x - EXP_X) : (EXP_X - sum_x);
   assign in_band = (diff <= TOL_X);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         gate_cnt <= '0;
         acc      <= '0;
      end else if (close) begin
         gate_cnt <= '0;
         acc      <= '0;
      end else begin
         gate_cnt <= gate_cnt + 1'b1;
         acc      <= acc_inc;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= ACQUIRE;
         good_cnt     <= '0;
         rst_out      <= 1'b1;
         freq_ok      <= 1'b0;
         edge_count   <= '0;
         count_valid  <= 1'b0;
         fault_sticky <= 1'b0;
      end else begin
         count_valid <= close;
         if (close) begin
            edge_count <= acc_inc;
            freq_ok    <= in_band;
            case (state)
               ACQUIRE: begin
                  if (!in_band) begin
                     good_cnt <= '0;
                  end else if (good_cnt == GOOD_LAST) begin
                     good_cnt <= '0;
                     state    <= RUN;
                     rst_out  <= 1'b0;
                  end else begin
                     good_cnt <= good_cnt + GCW'(1);
                  end
               end
               RUN: begin
                  if (!in_band) begin
                     good_cnt <= '0;
                     state    <= ACQUIRE;
                     rst_out  <= 1'b1;
                  end
               end
               default: state <= ACQUIRE;
            endcase
         end
         // A fault raised in the same cycle as a clear must survive.
         if (close && (state == RUN) && !in_band)
            fault_sticky <= 1'b1;
         else if (clr_fault)
            fault_sticky <= 1'b0;
      end
   end
endmodule
